// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage sequencer driving a req/ack data memory, plus the MEM/WB register.
// Misaligned accesses and memory timeouts become a sticky error and a terminal halt.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] AddrIn,
  input  logic [15:0] WrDataIn,
  input  logic [2:0]  WriteRegAddrIn,
  input  logic        MemEnableIn,
  input  logic        MemWrIn,
  input  logic        HaltIn,
  input  logic        Val2RegIn,
  input  logic        RegWriteIn,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [15:0] WbDataOut,
  output logic [2:0]  WriteRegAddrOut,
  output logic        RegWriteOut,
  output logic        HaltOut,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      wb_q;
  logic [2:0]       wra_q;
  logic             rw_q, halt_q, err_q;
  logic             go, timeout;
  assign go        = state_q == IDLE & MemEnableIn & ~AddrIn[0];
  assign timeout   = cnt_q == CNT_W'(TIMEOUT - 1);
  // Gated by reset so an access in flight is dropped the moment reset asserts
  assign mem_req   = rst & (go | state_q == WAIT);
  assign mem_wr    = mem_req & MemWrIn;
  assign stall     = rst & (go | state_q == HALTED | (state_q == WAIT & ~mem_ack));
  assign mem_addr  = AddrIn;
  assign mem_wdata = WrDataIn;
  assign WbDataOut       = wb_q;
  assign WriteRegAddrOut = wra_q;
  assign RegWriteOut     = rw_q;
  assign HaltOut         = halt_q;
  assign err             = err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
      wra_q   <= '0;
      rw_q    <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!MemEnableIn) begin
            wb_q    <= AddrIn;
            wra_q   <= WriteRegAddrIn;
            rw_q    <= RegWriteIn;
            halt_q  <= HaltIn;
            state_q <= HaltIn ? HALTED : IDLE;
          end else if (AddrIn[0]) begin
            err_q   <= 1'b1;
            halt_q  <= 1'b1;
            rw_q    <= 1'b0;
            state_q <= HALTED;
          end else begin
            rw_q    <= 1'b0;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            wb_q    <= Val2RegIn ? mem_rdata : AddrIn;
            wra_q   <= WriteRegAddrIn;
            rw_q    <= RegWriteIn;
            halt_q  <= HaltIn;
            state_q <= HaltIn ? HALTED : IDLE;
          end else if (timeout) begin
            err_q   <= 1'b1;
            halt_q  <= 1'b1;
            rw_q    <= 1'b0;
            state_q <= HALTED;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            rw_q    <= 1'b0;
            halt_q  <= 1'b0;
          end
        end
        HALTED: state_q <= HALTED;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed vectors push per-cycle expectations; a negedge monitor pops and compares.
module tb_mem_stage_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] AddrIn = '0, WrDataIn = '0, mem_rdata = '0;
  logic [2:0]  WriteRegAddrIn = '0;
  logic        MemEnableIn = 1'b0, MemWrIn = 1'b0, HaltIn = 1'b0, Val2RegIn = 1'b0, RegWriteIn = 1'b0, mem_ack = 1'b0;
  logic        mem_req, mem_wr, stall, RegWriteOut, HaltOut, err;
  logic [15:0] mem_addr, mem_wdata, WbDataOut;
  logic [2:0]  WriteRegAddrOut;
  typedef struct {
    string       t;
    logic [15:0] a, wd, wb;
    logic [2:0]  wa;
    logic        st, rq, wr, rw, h, e;
  } exp_t;
  exp_t q[$];
  exp_t m;
  int n_cmp = 0, n_err = 0;
  mem_stage_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst_n), .AddrIn(AddrIn), .WrDataIn(WrDataIn), .WriteRegAddrIn(WriteRegAddrIn),
    .MemEnableIn(MemEnableIn), .MemWrIn(MemWrIn), .HaltIn(HaltIn), .Val2RegIn(Val2RegIn),
    .RegWriteIn(RegWriteIn), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .WbDataOut(WbDataOut), .WriteRegAddrOut(WriteRegAddrOut), .RegWriteOut(RegWriteOut),
    .HaltOut(HaltOut), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string t, input string f, input logic [15:0] act, input logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s.%s got %h want %h", t, f, act, want);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (q.size() != 0) begin
      m = q.pop_front();
      chk(m.t, "stall", {15'd0, stall}, {15'd0, m.st});
      chk(m.t, "mem_req", {15'd0, mem_req}, {15'd0, m.rq});
      chk(m.t, "mem_wr", {15'd0, mem_wr}, {15'd0, m.wr});
      chk(m.t, "mem_addr", mem_addr, m.a);
      chk(m.t, "mem_wdata", mem_wdata, m.wd);
      chk(m.t, "WbDataOut", WbDataOut, m.wb);
      chk(m.t, "WriteRegAddrOut", {13'd0, WriteRegAddrOut}, {13'd0, m.wa});
      chk(m.t, "RegWriteOut", {15'd0, RegWriteOut}, {15'd0, m.rw});
      chk(m.t, "HaltOut", {15'd0, HaltOut}, {15'd0, m.h});
      chk(m.t, "err", {15'd0, err}, {15'd0, m.e});
    end
  end
  task automatic cyc(input string t, input logic r, input logic [15:0] a, wd, rd, input logic [2:0] wa,
                     input logic me, mw, h, v, rw, ack,
                     input logic es, ereq, ewr, input logic [15:0] ewb, input logic [2:0] ewa,
                     input logic erw, eh, ee);
    exp_t x;
    rst_n = r; AddrIn = a; WrDataIn = wd; mem_rdata = rd; WriteRegAddrIn = wa;
    MemEnableIn = me; MemWrIn = mw; HaltIn = h; Val2RegIn = v; RegWriteIn = rw; mem_ack = ack;
    x.t = t; x.a = a; x.wd = wd; x.wb = ewb; x.wa = ewa;
    x.st = es; x.rq = ereq; x.wr = ewr; x.rw = erw; x.h = eh; x.e = ee;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask
  task automatic idle_c(input string t, input logic es, ereq, ewr, input logic [15:0] ewb,
                        input logic [2:0] ewa, input logic erw, eh, ee);
    cyc(t, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, es, ereq, ewr, ewb, ewa, erw, eh, ee);
  endtask
  initial begin
    @(posedge clk);
    #1;
    cyc("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // ALU op, no memory
    cyc("alu", 1, 'h1234, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_c("alu_wb", 0, 0, 0, 'h1234, 3, 1, 0, 0);
    // Load, ack on the third WAIT cycle
    cyc("ld_req", 1, 'h0040, 0, 0, 5, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc("ld_wait", 1, 'h0040, 0, 0, 5, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("ld_ack", 1, 'h0040, 0, 'hBEEF, 5, 1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle_c("ld_wb", 0, 0, 0, 'hBEEF, 5, 1, 0, 0);
    // Store, immediate ack
    cyc("st_req", 1, 'h0010, 'h00AA, 0, 2, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    cyc("st_ack", 1, 'h0010, 'h00AA, 0, 2, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    idle_c("st_wb", 0, 0, 0, 'h0010, 2, 0, 0, 0);
    // Timeout: 1 IDLE + 15 WAIT request cycles, then halt
    cyc("to_req", 1, 'h0020, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    repeat (15) cyc("to_wait", 1, 'h0020, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc("to_halt", 1, 'h0020, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    cyc("rst2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Misaligned load
    cyc("mis", 1, 'h0011, 0, 0, 4, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc("mis_halt", 1, 'h0011, 0, 0, 4, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    cyc("rst3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Halt instruction, then a load that must not issue
    cyc("hlt", 1, 'h0077, 0, 0, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc("hlt_hold", 1, 'h0040, 0, 0, 5, 1, 0, 0, 1, 1, 0, 1, 0, 0, 'h0077, 6, 0, 1, 0);
    cyc("rst4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset asserted in the middle of a store's WAIT
    cyc("alu2", 1, 'h5555, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("st2_req", 1, 'h0040, 'h1111, 0, 2, 1, 1, 0, 0, 0, 0, 1, 1, 1, 'h5555, 7, 1, 0, 0);
    cyc("st2_wait", 1, 'h0040, 'h1111, 0, 2, 1, 1, 0, 0, 0, 0, 1, 1, 1, 'h5555, 7, 0, 0, 0);
    cyc("st2_rst", 0, 'h0040, 'h1111, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_c("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("ld2_req", 1, 'h0040, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc("ld2_ack", 1, 'h0040, 0, 'hCAFE, 1, 1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle_c("ld2_wb", 0, 0, 0, 'hCAFE, 1, 1, 0, 0);
    @(negedge clk);
    #1;
    chk("end", "queue_left", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
